secded_encoder: RTL and testbench

SECDED_ENCODER -- requirements
Module: secded_encoder

---
 rtl/ecc_pkg.sv | 41 ++++
 rtl/secded_ecc_calc.sv | 20 ++
 rtl/secded_encoder.sv | 107 ++++++++++
 tb/tb_secded_encoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: widths, inject modes, pipeline payload types and
// the data-to-codeword placement used by both encoder and decoder.
package ecc_pkg;
  localparam int DATA_W = 64;
  localparam int ECC_W  = 8;
  localparam int CW_W   = 72;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10
  } inj_mode_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ECC_W-1:0]  ecc;
    logic [1:0]        inj;
    logic [6:0]        pos;
  } s1_t;

  // ecc sits above data so a flat {ecc, data} view matches the inject vector
  typedef struct packed {
    logic [ECC_W-1:0]  ecc;
    logic [DATA_W-1:0] data;
  } fifo_ent_t;

  // Data fills every codeword index that is neither 0 nor a power of two.
  function automatic logic [CW_W-1:0] data_to_cw(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    int n;
    cw = '0;
    n  = 0;
    for (int j = 1; j < CW_W; j++) begin
      if ((j & (j - 1)) != 0) begin
        cw[j] = d[n];
        n++;
      end
    end
    return cw;
  endfunction
endpackage

// File: rtl/secded_ecc_calc.sv
// Combinational check-bit generator: ecc[0] is data parity, ecc[7:1] are the
// Hamming bits over the 72-bit codeword placement.
module secded_ecc_calc
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [ECC_W-1:0]  ecc
);
  logic [CW_W-1:0] cw;

  assign cw = data_to_cw(data);

  always_comb begin
    ecc    = '0;
    ecc[0] = ^data;
    for (int k = 1; k < ECC_W; k++)
      for (int j = 0; j < CW_W; j++)
        if (j[k-1]) ecc[k] = ecc[k] ^ cw[j];
  end
endmodule

// File: rtl/secded_encoder.sv
// SECDED encoder: one capture stage (ECC computed on accept) feeding a 2-entry
// in-order output FIFO; optional error injection is applied on the FIFO write.
module secded_encoder
  import ecc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        inject,
  input  logic [6:0]        inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [ECC_W-1:0]  ecc_out,
  output logic [15:0]       sent_count
);
  logic [ECC_W-1:0] ecc_calc;
  logic             rdy_en_q, rdy_en_d;
  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  fifo_ent_t [1:0]  mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [15:0]      sent_q, sent_d;
  logic             fifo_full, accept, push, pop;
  logic [CW_W-1:0]  flip_mask;
  logic [6:0]       pos_nx;
  fifo_ent_t        wr_ent;

  secded_ecc_calc u_calc (
    .data (data_in),
    .ecc  (ecc_calc)
  );

  // rdy_en_q keeps in_ready low while in reset and rises on the first edge after
  assign fifo_full  = (cnt_q == 2'd2);
  assign in_ready   = rdy_en_q && (!s1_valid_q || !fifo_full);
  assign accept     = in_valid && in_ready;
  assign push       = s1_valid_q && !fifo_full;
  assign out_valid  = (cnt_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign data_out   = mem_q[rd_ptr_q].data;
  assign ecc_out    = mem_q[rd_ptr_q].ecc;
  assign sent_count = sent_q;

  always_comb begin
    pos_nx    = (s1_q.pos == 7'(CW_W - 1)) ? 7'd0 : s1_q.pos + 7'd1;
    flip_mask = '0;
    if (s1_q.pos < 7'(CW_W)) begin
      if (s1_q.inj == INJ_SINGLE || s1_q.inj == INJ_DOUBLE) flip_mask[s1_q.pos] = 1'b1;
      if (s1_q.inj == INJ_DOUBLE) flip_mask[pos_nx] = 1'b1;
    end
    wr_ent = fifo_ent_t'({s1_q.ecc, s1_q.data} ^ flip_mask);
  end

  always_comb begin
    rdy_en_d   = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (push) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d       = '{data: data_in, ecc: ecc_calc, inj: inject, pos: inj_pos};
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_ent;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    sent_d = (pop && sent_q != 16'hFFFF) ? sent_q + 16'd1 : sent_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      sent_q     <= 16'd0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      sent_q     <= sent_d;
    end
  end
endmodule

// File: tb/tb_secded_encoder.sv
// Random + directed bench for secded_encoder: scoreboard of model-encoded
// words plus a behavioural loopback decoder for the injection modes.
module tb_secded_encoder;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] data_in, data_out;
  logic [1:0]  inject;
  logic [6:0]  inj_pos;
  logic [7:0]  ecc_out;
  logic [15:0] sent_count;

  secded_encoder dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .inject(inject), .inj_pos(inj_pos), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .ecc_out(ecc_out), .sent_count(sent_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  e;
    logic [63:0] orig;
    logic [1:0]  inj;
    logic [6:0]  pos;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_mis = 0, cyc = 0, pops = 0;
  int          d2cw[64];
  int          cw2d[128];
  bit          rnd_bp = 0;
  bit          prev_stall = 0;
  logic [71:0] prev_out;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Data bit i lands at the i-th slot of these codeword ranges.
  task automatic build_map();
    int lo[6] = '{3, 5, 9, 17, 33, 65};
    int hi[6] = '{3, 7, 15, 31, 63, 71};
    int n = 0;
    for (int i = 0; i < 128; i++) cw2d[i] = -1;
    for (int r = 0; r < 6; r++)
      for (int p = lo[r]; p <= hi[r]; p++) begin
        d2cw[n] = p;
        cw2d[p] = n;
        n++;
      end
  endtask

  // Hamming part = XOR of the codeword positions of all set data bits.
  function automatic logic [7:0] ref_ecc(input logic [63:0] d);
    logic [6:0] h = '0;
    for (int i = 0; i < 64; i++) if (d[i]) h ^= 7'(d2cw[i]);
    return {h, ^d};
  endfunction

  function automatic logic [71:0] ref_inj(input logic [71:0] v, input logic [1:0] m, input logic [6:0] p);
    int q = int'(p);
    if (q < 72 && (m == 2'b01 || m == 2'b10)) begin
      v[q] = ~v[q];
      if (m == 2'b10) v[(q + 1) % 72] = ~v[(q + 1) % 72];
    end
    return v;
  endfunction

  function automatic void ref_dec(input logic [63:0] d, input logic [7:0] e,
                                  output logic [1:0] flag, output logic [63:0] fix);
    logic [7:0] s;
    int di;
    s    = e ^ ref_ecc(d);
    fix  = d;
    flag = 2'b00;
    if (s != 8'h00) begin
      if (s[0]) begin
        if (s[7:1] == 7'd0) flag = 2'b01;
        else begin
          di = cw2d[s[7:1]];
          if (di >= 0) begin
            flag    = 2'b01;
            fix[di] = ~fix[di];
          end else flag = 2'b10;
        end
      end else flag = ((s[7:1] & (s[7:1] - 7'd1)) == 7'd0) ? 2'b01 : 2'b10;
    end
  endfunction

  task automatic mon_step();
    exp_t        x;
    logic [71:0] v;
    logic [1:0]  flag, m;
    logic [63:0] fix;
    if (!reset) begin
      prev_stall = 0;
      return;
    end
    if (prev_stall) chk("hold", {out_valid, ecc_out, data_out}, {1'b1, prev_out});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        x = sb.pop_front();
        pops++;
        chk("data", data_out, x.d);
        chk("ecc", ecc_out, x.e);
        ref_dec(data_out, ecc_out, flag, fix);
        m = ((x.inj == 2'b01 || x.inj == 2'b10) && x.pos < 7'd72) ? x.inj : 2'b00;
        if (m == 2'b00) chk("lb_clean", flag, 2'b00);
        else if (m == 2'b01) begin
          chk("lb_single", flag, 2'b01);
          chk("lb_fix", fix, x.orig);
        end else if (x.pos >= 7'd64 && x.pos <= 7'd70) chk("lb_double", flag, 2'b10);
        else chk("lb_dbl_det", flag != 2'b00, 1'b1);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {ecc_out, data_out};
    if (in_valid && in_ready) begin
      v = ref_inj({ref_ecc(data_in), data_in}, inject, inj_pos);
      sb.push_back('{d: v[63:0], e: v[71:64], orig: data_in, inj: inject, pos: inj_pos});
    end
  endtask

  always @(negedge clock) mon_step();

  task automatic send(input logic [63:0] d, input logic [1:0] inj, input logic [6:0] p);
    int t = 0;
    in_valid = 1'b1; data_in = d; inject = inj; inj_pos = p;
    forever begin
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (in_ready || t >= 100) break;
      @(posedge clock); #1;
      t++;
    end
    chk("accept", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] d, input logic [7:0] e, output int w);
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (!out_valid && w < 20);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_data"}, data_out, d);
    chk({tag, "_ecc"}, ecc_out, e);
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int t = 0;
    rnd_bp = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    chk("drain_vld", out_valid, 1'b0);
    chk("drain_sb", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_cnt", sent_count, 16'd0);
    chk("rst_out", {ecc_out, data_out}, 72'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rdy_after_rst", in_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, t0, p0;
    logic [63:0] a;
    build_map();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; inject = '0; inj_pos = '0;
    repeat (2) @(posedge clock); #1;
    chk("init_vld", out_valid, 1'b0);
    chk("init_rdy", in_ready, 1'b0);
    chk("init_cnt", sent_count, 16'd0);
    chk("init_out", {ecc_out, data_out}, 72'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    chk("rdy_after_rst", in_ready, 1'b1);

    out_ready = 1'b1;
    send(64'h0, 2'b00, 7'd0);                 expect_out("zero", 64'h0, 8'h00, w);
    chk("latency", w, 2);
    send(64'h1, 2'b00, 7'd0);                 expect_out("one", 64'h1, 8'h07, w);
    send(64'h8000_0000_0000_0000, 2'b00, 7'd0); expect_out("msb", 64'h8000_0000_0000_0000, 8'h8F, w);
    send(64'h0, 2'b01, 7'd0);                 expect_out("inj1", 64'h1, 8'h00, w);
    send(64'h0, 2'b10, 7'd71);                expect_out("inj2_wrap", 64'h1, 8'h80, w);
    send(64'h1, 2'b11, 7'd0);                 expect_out("inj_rsvd", 64'h1, 8'h07, w);
    send(64'h0, 2'b01, 7'd72);                expect_out("pos_oob", 64'h0, 8'h00, w);

    t0 = cyc;
    repeat (20) send({$urandom, $urandom}, 2'b00, 7'd0);
    chk("thruput", cyc - t0, 20);
    drain();

    do_reset();
    out_ready = 1'b0;
    a = 64'hA5A5_0000_1111_0001;
    send(a, 2'b00, 7'd0);
    send(64'hB, 2'b00, 7'd0);
    send(64'hC, 2'b00, 7'd0);
    in_valid = 1'b1; data_in = 64'hD; inject = 2'b00;
    repeat (3) @(negedge clock);
    chk("bp_full", in_ready, 1'b0);
    chk("bp_head", data_out, a);
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(64'hD, 2'b00, 7'd0);
    drain();
    chk("bp_count", sent_count, 16'd4);

    out_ready = 1'b0;
    send(64'h1111, 2'b00, 7'd0);
    send(64'h2222, 2'b00, 7'd0);
    send(64'h3333, 2'b00, 7'd0);
    chk("mid_buffered", {out_valid, in_ready}, 2'b10);
    do_reset();
    p0 = pops;
    out_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("no_leak", pops, p0);
    chk("no_leak_vld", out_valid, 1'b0);

    rnd_bp = 1;
    repeat (1000) send({$urandom, $urandom}, 2'b00, 7'($urandom_range(0, 127)));
    repeat (300) send({$urandom, $urandom}, 2'b01, 7'($urandom_range(0, 79)));
    repeat (300) send({$urandom, $urandom}, 2'b10, 7'($urandom_range(0, 79)));
    repeat (50) send({$urandom, $urandom}, 2'b10, 7'($urandom_range(64, 70)));
    repeat (50) send({$urandom, $urandom}, 2'b11, 7'($urandom_range(0, 71)));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
